// File: rtl/dft_pkg.sv
// rtl/dft_pkg.sv - shared state encoding and default widths for the DFT sample path
package dft_pkg;

  localparam int DFT_IQ_WIDTH           = 16;
  localparam int DFT_WINDOW_WIDTH       = 18;
  localparam int DFT_WIN_ADDR_WIDTH     = 10;
  localparam int DFT_SAMPLE_COUNT_WIDTH = 16;
  localparam int DFT_TIMEOUT_CYCLES     = 4096;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    DRAIN,
    WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/dft_frame_sequencer_if.sv
// rtl/dft_frame_sequencer_if.sv - upstream valid/ready I/Q sample stream
interface dft_frame_sequencer_if #(
  parameter int IQ_WIDTH = dft_pkg::DFT_IQ_WIDTH
);

  logic                       s_valid;
  logic                       s_ready;
  logic signed [IQ_WIDTH-1:0] s_i;
  logic signed [IQ_WIDTH-1:0] s_q;

  modport master (output s_valid, s_i, s_q, input s_ready);
  modport slave  (input s_valid, s_i, s_q, output s_ready);

endinterface

// File: rtl/dft_window_ram.sv
// rtl/dft_window_ram.sv - single-port window coefficient table, synchronous read, no reset
module dft_window_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents survive reset so a loaded window is reusable after recovery.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dft_frame_sequencer.sv
// rtl/dft_frame_sequencer.sv - frames an I/Q stream into windowed beats for the DFT accumulator
// Optional done watchdog: define DFT_SEQ_TIMEOUT_EN.
module dft_frame_sequencer
  import dft_pkg::*;
#(
  parameter int IQ_WIDTH           = DFT_IQ_WIDTH,
  parameter int WINDOW_WIDTH       = DFT_WINDOW_WIDTH,
  parameter int WIN_ADDR_WIDTH     = DFT_WIN_ADDR_WIDTH,
  parameter int SAMPLE_COUNT_WIDTH = DFT_SAMPLE_COUNT_WIDTH,
  parameter int TIMEOUT_CYCLES     = DFT_TIMEOUT_CYCLES
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [SAMPLE_COUNT_WIDTH-1:0] frame_len_i,
  input  logic                          win_we_i,
  input  logic [WIN_ADDR_WIDTH-1:0]     win_addr_i,
  input  logic [WINDOW_WIDTH-1:0]       win_data_i,
  dft_frame_sequencer_if.slave          up,
  output logic                          start_o,
  output logic                          sample_valid_o,
  output logic                          last_sample_o,
  output logic signed [IQ_WIDTH-1:0]    i_sample_o,
  output logic signed [IQ_WIDTH-1:0]    q_sample_o,
  output logic signed [WINDOW_WIDTH-1:0] window_coeff_o,
  input  logic                          dft_valid_i,
  output logic                          frame_done_o,
  output logic                          cfg_err_o,
  output logic                          timeout_o
);

  localparam logic [SAMPLE_COUNT_WIDTH-1:0] MAX_LEN = SAMPLE_COUNT_WIDTH'(2 ** WIN_ADDR_WIDTH);
  localparam logic [SAMPLE_COUNT_WIDTH-1:0] ONE     = SAMPLE_COUNT_WIDTH'(1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end

  seq_state_t                    state, next_state;
  logic [SAMPLE_COUNT_WIDTH-1:0] len_q, n_q, len_clamped;
  logic                          hs, last_hs, timeout_hit;
  logic                          sample_valid_q, last_q;
  logic                          ram_we;
  logic [WIN_ADDR_WIDTH-1:0]     ram_addr;
  logic [WINDOW_WIDTH-1:0]       ram_rdata;

  assign len_clamped = (frame_len_i > MAX_LEN) ? MAX_LEN : frame_len_i;
  assign hs          = up.s_valid && up.s_ready;
  assign last_hs     = hs && (n_q == len_q - ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (enable_i) next_state = START;
      START:     next_state = (frame_len_i == '0) ? IDLE : STREAM;
      STREAM:    if (last_hs) next_state = DRAIN;
      DRAIN:     next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (dft_valid_i) begin
          next_state = enable_i ? START : IDLE;
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    up.s_ready     = (state == STREAM) && (n_q < len_q);
    start_o        = (state == START) && (frame_len_i != '0);
    cfg_err_o      = (state == START) && (frame_len_i == '0);
    frame_done_o   = (state == WAIT_DONE) && dft_valid_i;
    timeout_o      = timeout_hit;
    sample_valid_o = sample_valid_q;
    last_sample_o  = last_q;
    window_coeff_o = sample_valid_q ? $signed(ram_rdata) : '0;
  end

  // Sample registers line up with the table's one-cycle read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q          <= '0;
      n_q            <= '0;
      sample_valid_q <= 1'b0;
      last_q         <= 1'b0;
      i_sample_o     <= '0;
      q_sample_o     <= '0;
    end else begin
      sample_valid_q <= hs;
      last_q         <= last_hs;
      if (state == START) begin
        len_q <= len_clamped;
        n_q   <= '0;
      end else if (hs) begin
        n_q <= n_q + ONE;
      end
      if (hs) begin
        i_sample_o <= up.s_i;
        q_sample_o <= up.s_q;
      end
    end
  end

  // The table port belongs to the host while idle and to the sample counter otherwise.
  assign ram_we   = win_we_i && (state == IDLE);
  assign ram_addr = (state == IDLE) ? win_addr_i : n_q[WIN_ADDR_WIDTH-1:0];

  dft_window_ram #(
    .ADDR_WIDTH (WIN_ADDR_WIDTH),
    .DATA_WIDTH (WINDOW_WIDTH)
  ) u_window_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .re    (hs),
    .addr  (ram_addr),
    .wdata (win_data_i),
    .rdata (ram_rdata)
  );

`ifdef DFT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_ONE = TW'(1);

  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + WD_ONE;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign timeout_hit = (state == WAIT_DONE) && !dft_valid_i && (wd_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// tb/tb_dft_frame_sequencer.sv - self-checking bench for dft_frame_sequencer
module tb_dft_frame_sequencer;

  localparam int IW = 16;
  localparam int WW = 18;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic win_we = 1'b0;
  logic dft_valid = 1'b0;
  logic [CW-1:0] frame_len = '0;
  logic [AW-1:0] win_addr = '0;
  logic [WW-1:0] win_data = '0;
  logic start, sample_valid, last_sample, frame_done, cfg_err, timeout;
  logic signed [IW-1:0] i_sample, q_sample;
  logic signed [WW-1:0] window_coeff;

  dft_frame_sequencer_if #(.IQ_WIDTH(IW)) up ();

  always #5 clk = ~clk;

  dft_frame_sequencer #(
    .IQ_WIDTH(IW), .WINDOW_WIDTH(WW), .WIN_ADDR_WIDTH(AW),
    .SAMPLE_COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .frame_len_i(frame_len),
    .win_we_i(win_we), .win_addr_i(win_addr), .win_data_i(win_data), .up(up),
    .start_o(start), .sample_valid_o(sample_valid), .last_sample_o(last_sample),
    .i_sample_o(i_sample), .q_sample_o(q_sample), .window_coeff_o(window_coeff),
    .dft_valid_i(dft_valid), .frame_done_o(frame_done), .cfg_err_o(cfg_err),
    .timeout_o(timeout)
  );

  typedef struct {
    logic signed [IW-1:0] i;
    logic signed [IW-1:0] q;
    logic signed [WW-1:0] c;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  logic signed [WW-1:0] tbl [1024];
  longint cap_c[$];
  int cap_cyc[$];
  int cap_last[$];
  int checks = 0;
  int errors = 0;
  int start_cnt = 0, cfg_cnt = 0, done_cnt = 0, to_cnt = 0, ready_cnt = 0;
  int cyc = 0, to_cyc = 0;
  logic prev_hs = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Every cycle: beats must follow handshakes by one cycle and match the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hs = 1'b0;
    end else begin
      cyc++;
      if (start) start_cnt++;
      if (cfg_err) cfg_cnt++;
      if (frame_done) done_cnt++;
      if (up.s_ready) ready_cnt++;
      if (timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      chk("valid_follows_handshake", longint'(sample_valid), longint'(prev_hs));
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_i", i_sample, e.i);
          chk("beat_q", q_sample, e.q);
          chk("beat_coeff", window_coeff, e.c);
          chk("beat_last", longint'(last_sample), longint'(e.last));
        end
        cap_c.push_back(window_coeff);
        cap_cyc.push_back(cyc);
        cap_last.push_back(int'(last_sample));
      end else begin
        chk("last_without_valid", longint'(last_sample), 0);
      end
      prev_hs = up.s_valid & up.s_ready;
    end
  end

  task automatic write_tbl(input int a, input int d, input bit accepted);
    win_we = 1'b1;
    win_addr = AW'(a);
    win_data = WW'(d);
    @(posedge clk); #1;
    win_we = 1'b0;
    if (accepted) tbl[a] = WW'(d);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 20 && !up.s_ready; t++) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer cnt samples of a flen-long frame, s_valid following pat (LSB first, patn long).
  task automatic drive_frame(input int flen, input int cnt, input int base,
                             input logic [31:0] pat, input int patn);
    int k;
    beat_t b;
    k = 0;
    for (int c = 0; c < 2000 && k < cnt; c++) begin
      up.s_valid = pat[c % patn];
      up.s_i = IW'(base + k + 1);
      up.s_q = IW'(-(base + k + 1));
      @(negedge clk);
      if (up.s_valid && up.s_ready) begin
        b.i = up.s_i;
        b.q = up.s_q;
        b.c = tbl[k];
        b.last = (k == flen - 1);
        exp_q.push_back(b);
        k++;
      end
      @(posedge clk); #1;
    end
    up.s_valid = 1'b0;
    chk("samples_accepted", k, cnt);
  endtask

  task automatic finish_frame();
    int d0;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    dft_valid = 1'b1;
    @(negedge clk); #1;
    chk("frame_done", done_cnt - d0, 1);
    @(posedge clk); #1;
    dft_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, longint'(start), 0);
    chk({tag, "_valid"}, longint'(sample_valid), 0);
    chk({tag, "_last"}, longint'(last_sample), 0);
    chk({tag, "_i"}, i_sample, 0);
    chk({tag, "_q"}, q_sample, 0);
    chk({tag, "_coeff"}, window_coeff, 0);
    chk({tag, "_done"}, longint'(frame_done), 0);
    chk({tag, "_cfg_err"}, longint'(cfg_err), 0);
    chk({tag, "_timeout"}, longint'(timeout), 0);
    chk({tag, "_ready"}, longint'(up.s_ready), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int s0, c0, r0, n0, d0;
    up.s_valid = 1'b0;
    up.s_i = '0;
    up.s_q = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 1024; k++) write_tbl(k, k * 3 + 5, 1'b1);
    for (int k = 0; k < 4; k++) write_tbl(k, (k + 1) * 1000, 1'b1);

    // Back-to-back frame, len 4
    frame_len = 4;
    s0 = start_cnt; n0 = cap_c.size();
    pulse_enable();
    drive_frame(4, 4, 0, 32'h1, 1);
    finish_frame();
    chk("t1_start_pulses", start_cnt - s0, 1);
    chk("t1_beats", cap_c.size() - n0, 4);
    chk("t1_coeff0", cap_c[n0], 1000);
    chk("t1_coeff3", cap_c[n0 + 3], 4000);
    chk("t1_last_on_beat3", cap_last[n0 + 2], 0);
    chk("t1_last_on_beat4", cap_last[n0 + 3], 1);
    chk("t1_consecutive", cap_cyc[n0 + 3] - cap_cyc[n0], 3);

    // Bubbles 1,0,0,1,1,0,1
    n0 = cap_c.size();
    pulse_enable();
    wait_ready();
    drive_frame(4, 4, 10, 32'h59, 7);
    finish_frame();
    chk("t2_span", cap_cyc[n0 + 3] - cap_cyc[n0], 6);
    chk("t2_gap", cap_cyc[n0 + 1] - cap_cyc[n0], 3);
    chk("t2_coeff1", cap_c[n0 + 1], 2000);

    // Zero-length frame is rejected
    frame_len = 0;
    s0 = start_cnt; c0 = cfg_cnt; r0 = ready_cnt;
    pulse_enable();
    repeat (4) @(posedge clk);
    #1;
    chk("t3_cfg_err", cfg_cnt - c0, 1);
    chk("t3_no_start", start_cnt - s0, 0);
    chk("t3_no_ready", ready_cnt - r0, 0);

    // Table write during STREAM is dropped
    frame_len = 4;
    n0 = cap_c.size();
    pulse_enable();
    wait_ready();
    write_tbl(1, 7, 1'b0);
    drive_frame(4, 4, 20, 32'h1, 1);
    finish_frame();
    pulse_enable();
    drive_frame(4, 4, 30, 32'h1, 1);
    finish_frame();
    chk("t4_f1_beat2", cap_c[n0 + 1], 2000);
    chk("t4_f2_beat2", cap_c[n0 + 5], 2000);

    // Enable held: WAIT_DONE restarts directly, then enable dropped mid-frame
    frame_len = 2;
    s0 = start_cnt; d0 = done_cnt;
    enable = 1'b1;
    drive_frame(2, 2, 60, 32'h1, 1);
    finish_frame();
    enable = 1'b0;
    drive_frame(2, 2, 70, 32'h1, 1);
    finish_frame();
    repeat (3) @(posedge clk);
    #1;
    chk("t5_restarts", start_cnt - s0, 2);
    chk("t5_done", done_cnt - d0, 2);

    // Async reset after two beats of a len-8 frame
    frame_len = 8;
    pulse_enable();
    drive_frame(8, 2, 40, 32'h1, 1);
    @(negedge clk); #1;
    chk("t6_scoreboard_drained", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame_len = 2;
    s0 = start_cnt; n0 = cap_c.size();
    pulse_enable();
    drive_frame(2, 2, 50, 32'h1, 1);
    finish_frame();
    chk("t6_restart", start_cnt - s0, 1);
    chk("t6_first_coeff", cap_c[n0], 1000);

    // Single-sample frame
    frame_len = 1;
    n0 = cap_c.size();
    pulse_enable();
    drive_frame(1, 1, 80, 32'h1, 1);
    finish_frame();
    chk("t7_len1_last", cap_last[n0], 1);

    // Oversized length clamps to the table depth
    frame_len = 1500;
    n0 = cap_c.size();
    pulse_enable();
    drive_frame(1024, 1024, 100, 32'h1, 1);
    r0 = ready_cnt;
    up.s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    up.s_valid = 1'b0;
    chk("t8_no_ready_after_clamp", ready_cnt - r0, 0);
    finish_frame();
    chk("t8_beats", cap_c.size() - n0, 1024);
    chk("t8_last_coeff", cap_c[n0 + 1023], 3074);
    chk("t8_last_flag", cap_last[n0 + 1023], 1);

    // dft_valid outside WAIT_DONE is ignored
    d0 = done_cnt;
    dft_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dft_valid = 1'b0;
    chk("idle_dft_valid_ignored", done_cnt - d0, 0);

`ifdef DFT_SEQ_TIMEOUT_EN
    frame_len = 1;
    c0 = to_cnt; n0 = cap_c.size();
    pulse_enable();
    drive_frame(1, 1, 90, 32'h1, 1);
    for (int t = 0; t < 40 && to_cnt == c0; t++) begin
      @(posedge clk); #1;
    end
    chk("timeout_pulses", to_cnt - c0, 1);
    chk("timeout_delay", to_cyc - cap_cyc[n0], TO + 1);
    d0 = done_cnt;
    dft_valid = 1'b1;
    @(posedge clk); #1;
    dft_valid = 1'b0;
    chk("timeout_back_to_idle", done_cnt - d0, 0);
`else
    chk("timeout_never", to_cnt, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
